sr_pair_monitor: RTL and testbench

//  Downstream consumer of the s/r pair produced by the SR-from-D converter stage.
//  - Models an SR latch clocked on clk and exposes its state as q/q_n.
//  - Classifies every sampled pair as set, reset, hold or illegal (s=r=1).
//  - Counts faults and output changes; enters a latched FAULT state on repeated illegal pairs.

---
 rtl/sr_pair_if.sv | 28 ++
 rtl/sr_pair_monitor.sv | 139 +++++++++++++
 tb/tb_sr_pair_monitor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sr_pair_if.sv
// s/r pair bundle from the SR-from-D stage plus the monitor's status view.
// Master drives the pair and clear, slave reports the modelled latch.
interface sr_pair_if #(
  parameter int CNT_W = 8
);
  logic             s;
  logic             r;
  logic             clr_err;
  logic             q;
  logic             q_n;
  logic             q_valid;
  logic             err;
  logic             fault;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output s, r, clr_err,
    input  q, q_n, q_valid, err, fault,
    input  err_cnt, chg_cnt
  );

  modport slave (
    input  s, r, clr_err,
    output q, q_n, q_valid, err, fault,
    output err_cnt, chg_cnt
  );
endinterface

// File: rtl/sr_pair_monitor.sv
// Clocked SR latch model with pair classification, counters and FAULT FSM.
// Define SR_MON_COMPL_CHECK_EN to flag HOLD (00) in TRACK as a protocol error.
module sr_pair_monitor #(
  parameter int CNT_W       = 8,
  parameter int FAULT_LIMIT = 4
) (
  input logic    clk,
  input logic    rst_n,
  sr_pair_if.slave bus
);
  typedef enum logic [1:0] {
    UNINIT = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [CNT_W:0] LIM = (CNT_W+1)'(FAULT_LIMIT);

  state_t           state, state_nx;
  logic             q, q_nx;
  logic             qv, qv_nx;
  logic             err, err_nx;
  logic [CNT_W-1:0] ecnt, ecnt_nx;
  logic [CNT_W-1:0] chg, chg_nx;
  logic [CNT_W-1:0] run, run_nx;

  logic             is_set, is_rst, is_ill, is_hold;
  logic [CNT_W-1:0] ecnt_inc;
  logic [CNT_W-1:0] run_inc;
  logic             hit;

  assign is_set  = bus.s & ~bus.r;
  assign is_rst  = ~bus.s & bus.r;
  assign is_ill  = bus.s & bus.r;
  assign is_hold = ~bus.s & ~bus.r;

  assign ecnt_inc = (ecnt == '1) ? ecnt : ecnt + 1'b1;
  assign run_inc  = (run == '1) ? run : run + 1'b1;
  assign hit      = ({1'b0, run} + 1'b1) == LIM;

  always_comb begin
    state_nx = state;
    q_nx     = q;
    qv_nx    = qv;
    err_nx   = err;
    ecnt_nx  = ecnt;
    chg_nx   = chg;
    run_nx   = run;
    // clear wins over whatever pair arrives with it
    if (bus.clr_err) begin
      err_nx   = 1'b0;
      ecnt_nx  = '0;
      run_nx   = '0;
      qv_nx    = 1'b0;
      state_nx = UNINIT;
    end else begin
      unique case (state)
        UNINIT: begin
          qv_nx = 1'b0;
          if (is_set || is_rst) begin
            q_nx     = is_set;
            qv_nx    = 1'b1;
            run_nx   = '0;
            state_nx = TRACK;
          end else if (is_ill) begin
            err_nx  = 1'b1;
            ecnt_nx = ecnt_inc;
            run_nx  = run_inc;
            if (hit) state_nx = FAULT;
          end else if (is_hold) begin
`ifndef SR_MON_COMPL_CHECK_EN
            run_nx = '0;
`endif
          end
        end
        TRACK: begin
          if (is_set || is_rst) begin
            run_nx = '0;
            if (q != is_set) begin
              q_nx   = is_set;
              chg_nx = chg + 1'b1;
            end
          end else if (is_ill) begin
            err_nx  = 1'b1;
            ecnt_nx = ecnt_inc;
            run_nx  = run_inc;
            if (hit) begin
              state_nx = FAULT;
              qv_nx    = 1'b0;
            end
          end else if (is_hold) begin
`ifdef SR_MON_COMPL_CHECK_EN
            err_nx  = 1'b1;
            ecnt_nx = ecnt_inc;
`else
            run_nx = '0;
`endif
          end
        end
        FAULT: begin
          qv_nx = 1'b0;
          if (is_ill) begin
            err_nx  = 1'b1;
            ecnt_nx = ecnt_inc;
          end
        end
        default: state_nx = UNINIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNINIT;
      q     <= 1'b0;
      qv    <= 1'b0;
      err   <= 1'b0;
      ecnt  <= '0;
      chg   <= '0;
      run   <= '0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      qv    <= qv_nx;
      err   <= err_nx;
      ecnt  <= ecnt_nx;
      chg   <= chg_nx;
      run   <= run_nx;
    end
  end

  assign bus.q       = q;
  assign bus.q_n     = ~q;
  assign bus.q_valid = qv;
  assign bus.err     = err;
  assign bus.fault   = (state == FAULT);
  assign bus.err_cnt = ecnt;
  assign bus.chg_cnt = chg;
endmodule

// File: tb/tb_sr_pair_monitor.sv
// Directed bench for sr_pair_monitor: default build (8-bit) and a
// 2-bit instance for saturation / wrap behaviour.
module tb_sr_pair_monitor;
  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  sr_pair_if #(.CNT_W(8)) a ();
  sr_pair_if #(.CNT_W(2)) b ();

  sr_pair_monitor #(
    .CNT_W(8),
    .FAULT_LIMIT(4)
  ) dut_a (
    .clk(clk),
    .rst_n(rst_n),
    .bus(a.slave)
  );

  sr_pair_monitor #(
    .CNT_W(2),
    .FAULT_LIMIT(3)
  ) dut_b (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic stepa(input logic s, input logic r, input logic c);
    @(negedge clk);
    a.s = s;
    a.r = r;
    a.clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic stepb(input logic s, input logic r);
    @(negedge clk);
    b.s = s;
    b.r = r;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] e0;

  initial begin
    total  = 0;
    passed = 0;
`ifdef SR_MON_COMPL_CHECK_EN
    e0 = 8'd1;
`else
    e0 = 8'd0;
`endif
    rst_n = 1'b0;
    a.s = 0; a.r = 0; a.clr_err = 0;
    b.s = 0; b.r = 0; b.clr_err = 0;
    #12;
    chk("rst_q", a.q, 0);
    chk("rst_qn", a.q_n, 1);
    chk("rst_qv", a.q_valid, 0);
    chk("rst_err", a.err, 0);
    chk("rst_fault", a.fault, 0);
    chk("rst_ecnt", a.err_cnt, 0);
    chk("rst_chg", a.chg_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // tracking 10,00,01,10
    stepa(1, 0, 0);
    chk("trk1_q", a.q, 1);
    chk("trk1_qv", a.q_valid, 1);
    chk("trk1_chg", a.chg_cnt, 0);
    stepa(0, 0, 0);
    chk("trk2_q", a.q, 1);
    chk("trk2_ecnt", a.err_cnt, e0);
    stepa(0, 1, 0);
    chk("trk3_q", a.q, 0);
    chk("trk3_qn", a.q_n, 1);
    stepa(1, 0, 0);
    chk("trk4_q", a.q, 1);
    chk("trk4_chg", a.chg_cnt, 2);

    // clear then re-enter TRACK with q already 1
    stepa(0, 0, 1);
    chk("clr0_err", a.err, 0);
    chk("clr0_qv", a.q_valid, 0);
    stepa(1, 0, 0);
    chk("re_qv", a.q_valid, 1);
    chk("re_chg", a.chg_cnt, 2);

    // fault entry: 3x11, 10, 4x11
    repeat (3) stepa(1, 1, 0);
    chk("f3_fault", a.fault, 0);
    chk("f3_ecnt", a.err_cnt, 3);
    chk("f3_qv", a.q_valid, 1);
    stepa(1, 0, 0);
    repeat (3) stepa(1, 1, 0);
    chk("f6_fault", a.fault, 0);
    stepa(1, 1, 0);
    chk("f7_fault", a.fault, 1);
    chk("f7_qv", a.q_valid, 0);
    chk("f7_ecnt", a.err_cnt, 7);
    chk("f7_err", a.err, 1);
    stepa(0, 1, 0);
    chk("frz_q", a.q, 1);
    chk("frz_fault", a.fault, 1);
    stepa(1, 1, 0);
    chk("fill_ecnt", a.err_cnt, 8);

    // clear with 11 in FAULT
    stepa(1, 1, 1);
    chk("clr_err", a.err, 0);
    chk("clr_ecnt", a.err_cnt, 0);
    chk("clr_fault", a.fault, 0);
    chk("clr_qv", a.q_valid, 0);
    chk("clr_q", a.q, 1);
    chk("clr_chg", a.chg_cnt, 2);
    stepa(1, 0, 1);
    chk("clrset_qv", a.q_valid, 0);
    chk("clrset_q", a.q, 1);
    stepa(0, 1, 0);
    chk("ld_q", a.q, 0);
    chk("ld_qv", a.q_valid, 1);
    chk("ld_chg", a.chg_cnt, 2);

    // async reset mid-cycle
    stepa(1, 0, 0);
    repeat (3) stepa(1, 1, 0);
    chk("pre_q", a.q, 1);
    chk("pre_ecnt", a.err_cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_q", a.q, 0);
    chk("ar_qn", a.q_n, 1);
    chk("ar_ecnt", a.err_cnt, 0);
    chk("ar_qv", a.q_valid, 0);
    chk("ar_chg", a.chg_cnt, 0);
    @(negedge clk);
    a.s = 0; a.r = 0;
    rst_n = 1'b1;

    // HOLD in TRACK
    stepa(1, 0, 0);
    stepa(0, 0, 0);
    chk("hold_err", a.err, e0[0]);
    chk("hold_ecnt", a.err_cnt, e0);
    chk("hold_fault", a.fault, 0);
    chk("hold_q", a.q, 1);

    // 2-bit instance: saturation and wrap
    stepb(1, 1);
    stepb(1, 0);
    chk("b_q", b.q, 1);
    stepb(1, 1);
    stepb(0, 1);
    stepb(1, 1);
    chk("b_ecnt3", b.err_cnt, 3);
    stepb(1, 0);
    stepb(1, 1);
    stepb(0, 1);
    chk("b_chg3", b.chg_cnt, 3);
    stepb(1, 1);
    chk("b_ecnt5", b.err_cnt, 3);
    chk("b_err", b.err, 1);
    chk("b_fault", b.fault, 0);
    stepb(1, 0);
    chk("b_chg4", b.chg_cnt, 0);
    stepb(0, 1);
    chk("b_chg5", b.chg_cnt, 1);
    chk("b_q5", b.q, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
